// File: rtl/gemm_c_tile_writeback.sv
// Buffers up to two GeMM result tiles and writes them one element per cycle to C SRAM.
// Optional macro GEMM_WB_SAT_EN: signed saturation when narrowing elements (otherwise truncation).
module gemm_c_tile_writeback #(
   parameter int OutDataWidth  = 32,
   parameter int OutWordWidth  = 32,
   parameter int AddrWidth     = 16,
   parameter int SizeAddrWidth = 8,
   parameter int M             = 4,
   parameter int N             = 4
) (
   input  logic                             clk_i,
   input  logic                             rst_ni,
   input  logic                             tile_valid_i,
   output logic                             tile_ready_o,
   input  logic [AddrWidth-1:0]             tile_addr_i,
   input  logic [OutDataWidth*M*N-1:0]      tile_data_i,
   input  logic [SizeAddrWidth-1:0]         N_size_i,
   output logic [AddrWidth-1:0]             mem_addr_o,
   output logic [OutWordWidth-1:0]          mem_wdata_o,
   output logic                             mem_we_o,
   input  logic                             mem_gnt_i,
   output logic                             busy_o,
   output logic                             drop_o
);

   localparam int TileW = OutDataWidth * M * N;
   localparam int Elems = M * N;
   localparam int EW    = (Elems > 1) ? $clog2(Elems) : 1;
   localparam int MW    = (M > 1) ? $clog2(M) : 1;
   localparam int NW    = (N > 1) ? $clog2(N) : 1;

`ifdef GEMM_WB_SAT_EN
   localparam logic [OutDataWidth-1:0] SatMax =
      {{(OutDataWidth-OutWordWidth+1){1'b0}}, {(OutWordWidth-1){1'b1}}};
   localparam logic [OutDataWidth-1:0] SatMin =
      {{(OutDataWidth-OutWordWidth+1){1'b1}}, {(OutWordWidth-1){1'b0}}};
`endif

   typedef enum logic {IDLE, DRAIN} state_e;

   state_e                   state_q;
   logic [TileW-1:0]         data_q   [2];
   logic [AddrWidth-1:0]     base_q   [2];
   logic [SizeAddrWidth-1:0] stride_q [2];
   logic                     wr_ptr_q;
   logic                     rd_ptr_q;
   logic [1:0]               count_q;
   logic                     drop_q;
   logic [MW-1:0]            m_q;
   logic [NW-1:0]            n_q;
   logic [EW-1:0]            e_q;
   logic [AddrWidth-1:0]     row_off_q;

   logic                     push;
   logic                     pop;
   logic                     grant;
   logic                     draining;
   logic                     last_col;
   logic                     last_row;
   logic [OutDataWidth-1:0]  elem;

   function automatic logic [OutWordWidth-1:0] narrow(input logic [OutDataWidth-1:0] v);
`ifdef GEMM_WB_SAT_EN
      if ($signed(v) > $signed(SatMax)) return SatMax[OutWordWidth-1:0];
      else if ($signed(v) < $signed(SatMin)) return SatMin[OutWordWidth-1:0];
      else return v[OutWordWidth-1:0];
`else
      return v[OutWordWidth-1:0];
`endif
   endfunction

   // Ready depends only on registered occupancy so the producer sees no combinational path.
   assign tile_ready_o = (count_q != 2'd2);
   assign push         = tile_valid_i & tile_ready_o;
   assign draining     = (state_q == DRAIN);
   assign grant        = draining & mem_gnt_i;
   assign last_col     = (n_q == NW'(N-1));
   assign last_row     = (m_q == MW'(M-1));
   assign pop          = grant & last_col & last_row;

   assign elem         = data_q[rd_ptr_q][int'(e_q)*OutDataWidth +: OutDataWidth];
   assign mem_we_o     = draining;
   assign mem_addr_o   = draining ? (base_q[rd_ptr_q] + row_off_q + AddrWidth'(n_q)) : '0;
   assign mem_wdata_o  = draining ? narrow(elem) : '0;
   assign busy_o       = (count_q != 2'd0) | draining;
   assign drop_o       = drop_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         for (int i = 0; i < 2; i++) begin
            data_q[i]   <= '0;
            base_q[i]   <= '0;
            stride_q[i] <= '0;
         end
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
         drop_q    <= 1'b0;
         m_q       <= '0;
         n_q       <= '0;
         e_q       <= '0;
         row_off_q <= '0;
      end else begin
         if (push) begin
            data_q[wr_ptr_q]   <= tile_data_i;
            base_q[wr_ptr_q]   <= tile_addr_i;
            stride_q[wr_ptr_q] <= N_size_i;
            wr_ptr_q           <= ~wr_ptr_q;
         end
         if (pop) rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + {1'b0, push} - {1'b0, pop};
         // Producer cannot stall, so an offer while full is lost and remembered until reset.
         if (tile_valid_i && !tile_ready_o) drop_q <= 1'b1;

         case (state_q)
            IDLE: begin
               // A tile being captured this edge is already the FIFO head, so drain starts next cycle.
               if (count_q != 2'd0 || push) state_q <= DRAIN;
            end
            DRAIN: begin
               if (grant) begin
                  if (last_col) begin
                     n_q <= '0;
                     if (last_row) begin
                        m_q       <= '0;
                        e_q       <= '0;
                        row_off_q <= '0;
                        if (count_q == 2'd1 && !push) state_q <= IDLE;
                     end else begin
                        m_q       <= m_q + 1'b1;
                        e_q       <= e_q + 1'b1;
                        row_off_q <= row_off_q + AddrWidth'(stride_q[rd_ptr_q]);
                     end
                  end else begin
                     n_q <= n_q + 1'b1;
                     e_q <= e_q + 1'b1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gemm_c_tile_writeback.sv
// Scoreboard bench for gemm_c_tile_writeback: reference model expands captured tiles into expected writes.
module tb_gemm_c_tile_writeback;
   localparam int DW = 32;
   localparam int WW = 32;
   localparam int AW = 16;
   localparam int SW = 8;
   localparam int M  = 4;
   localparam int N  = 4;
   localparam int TW = DW*M*N;
   localparam int W2 = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tile_valid = 1'b0;
   logic          tile_ready;
   logic [AW-1:0] tile_addr = '0;
   logic [TW-1:0] tile_data = '0;
   logic [SW-1:0] n_size = '0;
   logic [AW-1:0] mem_addr;
   logic [WW-1:0] mem_wdata;
   logic          mem_we;
   logic          mem_gnt = 1'b1;
   logic          busy;
   logic          drop;

   logic          v2 = 1'b0;
   logic          rdy2;
   logic [AW-1:0] a2 = '0;
   logic [2*DW-1:0] d2 = '0;
   logic [SW-1:0] s2 = '0;
   logic [AW-1:0] wa2;
   logic [W2-1:0] wd2;
   logic          we2;
   logic          gnt2 = 1'b1;
   logic          busy2;
   logic          drop2;

   int checks = 0;
   int failures = 0;
   logic [AW+WW-1:0] exp_q[$];
   logic [AW+W2-1:0] exp2_q[$];
   int occ = 0;
   int wr_cnt = 0;
   logic drop_m = 1'b0;

   always #5 clk = ~clk;

   gemm_c_tile_writeback #(.OutDataWidth(DW), .OutWordWidth(WW), .AddrWidth(AW),
      .SizeAddrWidth(SW), .M(M), .N(N)) dut (
      .clk_i(clk), .rst_ni(rst_n), .tile_valid_i(tile_valid), .tile_ready_o(tile_ready),
      .tile_addr_i(tile_addr), .tile_data_i(tile_data), .N_size_i(n_size),
      .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_we_o(mem_we),
      .mem_gnt_i(mem_gnt), .busy_o(busy), .drop_o(drop));

   gemm_c_tile_writeback #(.OutDataWidth(DW), .OutWordWidth(W2), .AddrWidth(AW),
      .SizeAddrWidth(SW), .M(1), .N(2)) dut_narrow (
      .clk_i(clk), .rst_ni(rst_n), .tile_valid_i(v2), .tile_ready_o(rdy2),
      .tile_addr_i(a2), .tile_data_i(d2), .N_size_i(s2),
      .mem_addr_o(wa2), .mem_wdata_o(wd2), .mem_we_o(we2),
      .mem_gnt_i(gnt2), .busy_o(busy2), .drop_o(drop2));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W2-1:0] ref_narrow8(input int v);
      int r;
`ifdef GEMM_WB_SAT_EN
      r = (v > 127) ? 127 : ((v < -128) ? -128 : v);
`else
      r = v;
`endif
      return r[W2-1:0];
   endfunction

   // Main scoreboard: model occupancy is tiles captured minus tiles fully written.
   always @(negedge clk) begin
      logic cap;
      logic done;
      logic [AW+WW-1:0] e;
      logic [AW-1:0] a;
      if (!rst_n) begin
         chk("rst_ready", tile_ready, 1);
         chk("rst_we", mem_we, 0);
         chk("rst_busy", busy, 0);
         chk("rst_drop", drop, 0);
         chk("rst_addr", mem_addr, 0);
         chk("rst_wdata", mem_wdata, 0);
         exp_q.delete();
         occ = 0;
         wr_cnt = 0;
         drop_m = 1'b0;
      end else begin
         chk("ready", tile_ready, occ < 2);
         chk("busy", busy, occ > 0);
         chk("we", mem_we, occ > 0);
         chk("drop", drop, drop_m);
         done = 1'b0;
         if (mem_we) begin
            if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               e = exp_q[0];
               chk("addr", mem_addr, e[AW+WW-1:WW]);
               chk("wdata", mem_wdata, e[WW-1:0]);
               if (mem_gnt) begin
                  void'(exp_q.pop_front());
                  wr_cnt++;
                  if (wr_cnt == M*N) begin
                     wr_cnt = 0;
                     done = 1'b1;
                  end
               end
            end
         end
         cap = tile_valid && (occ < 2);
         if (tile_valid && occ == 2) drop_m = 1'b1;
         if (cap) begin
            for (int m = 0; m < M; m++)
               for (int n = 0; n < N; n++) begin
                  a = AW'(int'(tile_addr) + m*int'(n_size) + n);
                  exp_q.push_back({a, tile_data[(m*N+n)*DW +: DW]});
               end
         end
         occ = occ + int'(cap) - int'(done);
      end
   end

   always @(negedge clk) begin
      if (rst_n && we2) begin
         if (exp2_q.size() == 0) chk("narrow_unexpected", 1, 0);
         else begin
            chk("narrow_addr", wa2, exp2_q[0][AW+W2-1:W2]);
            chk("narrow_wdata", wd2, exp2_q[0][W2-1:0]);
            void'(exp2_q.pop_front());
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [AW-1:0] base, input logic [SW-1:0] stride,
                        input logic [TW-1:0] data);
      tile_valid = 1'b1;
      tile_addr  = base;
      n_size     = stride;
      tile_data  = data;
      tick();
      tile_valid = 1'b0;
      n_size     = SW'($urandom);
   endtask

   function automatic logic [TW-1:0] rand_tile();
      logic [TW-1:0] t;
      for (int i = 0; i < M*N; i++) t[i*DW +: DW] = $urandom;
      return t;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      logic [TW-1:0] t;
      do_reset();

      // single tile, element(m,n) = m*4+n
      mem_gnt = 1'b1;
      for (int i = 0; i < M*N; i++) t[i*DW +: DW] = i;
      offer(16'h0010, 8'd8, t);
      repeat (20) tick();

      // back-to-back tiles
      offer(16'h0000, 8'd8, rand_tile());
      offer(16'h0004, 8'd8, rand_tile());
      repeat (40) tick();

      // backpressure on the 5th element
      offer(16'h0100, 8'd16, rand_tile());
      repeat (4) tick();
      mem_gnt = 1'b0;
      repeat (3) tick();
      mem_gnt = 1'b1;
      repeat (20) tick();

      // overflow with grant held low
      mem_gnt = 1'b0;
      offer(16'h0200, 8'd4, rand_tile());
      offer(16'h0300, 8'd4, rand_tile());
      offer(16'h0400, 8'd4, rand_tile());
      repeat (3) tick();
      mem_gnt = 1'b1;
      repeat (40) tick();

      // randomized traffic including wrap-around bases
      for (int c = 0; c < 400; c++) begin
         mem_gnt = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 2) offer(AW'($urandom), SW'($urandom), rand_tile());
         else tick();
      end
      mem_gnt = 1'b1;
      repeat (40) tick();

      // reset during the 7th write
      do_reset();
      offer(16'h0500, 8'd8, rand_tile());
      repeat (6) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (10) tick();

      // narrowing: 300 and -200 into 8-bit words
      v2 = 1'b1;
      a2 = 16'h0040;
      s2 = 8'd2;
      d2 = {32'hFFFF_FF38, 32'd300};
      exp2_q.push_back({16'h0040, ref_narrow8(300)});
      exp2_q.push_back({16'h0041, ref_narrow8(-200)});
      tick();
      v2 = 1'b0;
      repeat (6) tick();

      chk("exp_q_empty", exp_q.size(), 0);
      chk("exp2_q_empty", exp2_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
